// File: rtl/axi_mem_req_master.sv
// Core req/gnt/rvalid port to a single-beat AXI4 master, one transaction in flight.
// Optional macro AXI_MASTER_ERR_EN: report SLVERR/DECERR from B/R on data_err_o.
module axi_mem_req_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 2,
  parameter int unsigned AXI_ID_VALUE   = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_wdata_i,
  output logic [AXI_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [1:0]                  b_resp_i,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i
);

  // state        | meaning
  // IDLE         | waiting for a core request; gnt follows req
  // WR_ADDR_DATA | AW and W offered independently until both have handshaken
  // WR_RESP      | b_ready high until B, then holds through the rvalid pulse
  // RD_ADDR      | AR offered until ar_ready
  // RD_DATA      | r_ready high until R, then holds through the rvalid pulse
  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t                      state;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] be_q;

  assign data_gnt_o = data_req_i && (state == IDLE);
  assign aw_addr_o  = addr_q;
  assign ar_addr_o  = addr_q;
  assign w_data_o   = wdata_q;
  assign w_strb_o   = be_q;
  assign w_last_o   = 1'b1;
  assign aw_id_o    = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign ar_id_o    = AXI_ID_WIDTH'(AXI_ID_VALUE);

`ifdef AXI_MASTER_ERR_EN
  logic err_q;
  logic unused_in;
  assign data_err_o = err_q;
  assign unused_in  = ^{b_resp_i[0], r_resp_i[0], r_last_i};
`else
  logic unused_in;
  assign data_err_o = 1'b0;
  assign unused_in  = ^{b_resp_i, r_resp_i, r_last_i};
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      aw_valid_o    <= 1'b0;
      w_valid_o     <= 1'b0;
      b_ready_o     <= 1'b0;
      ar_valid_o    <= 1'b0;
      r_ready_o     <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
`ifdef AXI_MASTER_ERR_EN
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (data_gnt_o) begin
            addr_q  <= data_addr_i;
            wdata_q <= data_wdata_i;
            be_q    <= data_be_i;
            if (data_we_i) begin
              aw_valid_o <= 1'b1;
              w_valid_o  <= 1'b1;
              state      <= WR_ADDR_DATA;
            end else begin
              ar_valid_o <= 1'b1;
              state      <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (aw_valid_o && aw_ready_i) aw_valid_o <= 1'b0;
          if (w_valid_o && w_ready_i) w_valid_o <= 1'b0;
          // both channels are done once each is either already cleared or handshaking now
          if ((!aw_valid_o || aw_ready_i) && (!w_valid_o || w_ready_i)) begin
            b_ready_o <= 1'b1;
            state     <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (data_rvalid_o) begin
            data_rvalid_o <= 1'b0;
            state         <= IDLE;
          end else if (b_valid_i && b_ready_o) begin
            b_ready_o     <= 1'b0;
            data_rvalid_o <= 1'b1;
`ifdef AXI_MASTER_ERR_EN
            err_q         <= b_resp_i[1];
`endif
          end
        end
        RD_ADDR: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (data_rvalid_o) begin
            data_rvalid_o <= 1'b0;
            state         <= IDLE;
          end else if (r_valid_i && r_ready_o) begin
            r_ready_o     <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_rdata_o  <= r_data_i;
`ifdef AXI_MASTER_ERR_EN
            err_q         <= r_resp_i[1];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
